keypad_scan_4x4: RTL and testbench
==================================

Name: keypad_scan_4x4

Overview:
Scanned-input counterpart to the multiplexed seg7x16 display path. Drives the rows of a 4x4 matrix keypad one at a time and samples the active-low columns. Debounces over whole scan frames and reports single key presses as hex codes. Keeps an 8-digit shift register of entered keys, 32 bits wide, that can feed seg7x16 directly or serve as CPU/board input in place of the slide switches.

Parameters:
SCAN_DIV, 1000, clk cycles each row is driven before sampling; must be >= 2
DEBOUNCE, 4, consecutive identical frames required to accept a press or a release; must be >= 2

Ports:
clk  input  1  system clock, the single clock domain
reset  input  1  synchronous, active-low reset
col_i  input  4  keypad columns, active-low, externally pulled up; asynchronous
clr  input  1  synchronous clear of digits
row_o  output  4  row drive, one-cold: the selected row is 0
key_code  output  4  code of the last accepted key, = row*4 + col
key_valid  output  1  one-cycle pulse when a press is accepted
key_down  output  1  high from press acceptance until release acceptance
digits  output  32  last 8 accepted codes; newest in [3:0]

Behaviour:
- Reset: applies at a clk edge with reset==0. Values after reset:
  - row index 0, row_o=4'b1110, divider 0
  - col synchronizer stages all 4'hF
  - FSM IDLE, frame counter 0, candidate 0
  - key_code=0, key_valid=0, key_down=0, digits=0
  - Reset mid-press drops the press with no key_valid.
- Synchronizer: col_i passes through two flops (col_s) before any use.
- Scan timing:
  - The divider counts 0..SCAN_DIV-1.
  - On the terminal count, ~col_s is sampled into the slot for the current row, and the row index advances modulo 4.
  - row_o = ~(4'b0001 << row) at all times.
  - One frame = 4*SCAN_DIV cycles.
- Frame evaluation:
  - Triggered on the terminal count of row 3.
  - Classify the 16 sampled bits as NONE (0 set), SINGLE (exactly 1 set, code = row*4 + col, col0 = bit0) or MULTI (2 or more set).
  - The classification and code are registered and consumed by the FSM on the next cycle. The FSM changes state at most once per frame.
- FSM (cnt = frame counter):
  - IDLE: on SINGLE, cand=code, cnt=1 -> DB_PRESS. On NONE or MULTI, stay.
  - DB_PRESS:
    - SINGLE with code==cand: cnt+1. When cnt+1==DEBOUNCE -> PRESSED, with key_code=cand, key_valid=1 for one cycle, key_down=1.
    - Any other result -> IDLE, cnt=0.
  - PRESSED: on NONE, cnt=1 -> DB_REL. On SINGLE (any code) or MULTI, stay, with no new key_valid (no auto-repeat).
  - DB_REL:
    - NONE: cnt+1. When cnt+1==DEBOUNCE -> IDLE, key_down=0.
    - SINGLE or MULTI -> PRESSED, cnt=0, with no new key_valid.
- Digits:
  - On key_valid, digits <= {digits[27:0], key_code}. The oldest nibble is discarded, so the register wraps after 8 keys.
  - clr==1 sets digits to 0 on that edge.
  - If clr and key_valid occur in the same cycle, clr wins: digits=0. key_valid and key_code are still reported.
- Latency: key_valid rises 1 cycle after the frame-end edge of the DEBOUNCE-th matching frame.
- Ghosting: a MULTI frame never produces a key, never resets PRESSED, and aborts DB_PRESS.

Test Plan:
Bench parameters: SCAN_DIV=4, DEBOUNCE=3. The keypad model pulls col low when the driven row matches.
1. Reset and scan: hold reset=0 for 3 cycles, then release -> row_o=1110 and all outputs 0. row_o steps 1110, 1101, 1011, 0111 every 4 cycles, then wraps.
2. Clean press: hold row 1/col 2 for 5 frames, then release -> exactly one key_valid pulse with key_code=6, digits=32'h00000006. key_down stays high until 3 NONE frames have been evaluated, then falls.
3. Bounce: toggle key 0xF with a 1-frame press, 1-frame release, then a steady press -> the aborted attempt gives no pulse. The steady press gives one key_valid with code F, 3 frames after the steady press begins.
4. Two keys and release glitch: hold keys 3 and 9 together -> no key_valid. Then press 5 and, while held, glitch to NONE for 1 frame -> key_down stays 1 and only one key_valid with code 5.
5. Wrap and clear: enter 1,2,3,4,5,6,7,8,9 -> digits=32'h23456789. Assert clr in the same cycle as the pulse for key A -> digits=0 while key_code=A.
6. Mid-operation reset: apply reset=0 during DB_PRESS and again during PRESSED -> no key_valid, key_down=0, FSM in IDLE. Re-pressing afterwards yields a normal pulse.

Source files
------------

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: one-cold row drive, frame-level debounce,
// single-press reporting as hex codes and an 8-digit entry shift register.
//
// state      | meaning
// S_IDLE     | no key held, waiting for a clean single-key frame
// S_DB_PRESS | same key seen in r_cnt consecutive frames
// S_PRESSED  | press accepted, waiting for an empty frame
// S_DB_REL   | empty keypad seen in r_cnt consecutive frames
module keypad_scan_4x4 #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col_i,
  input  logic        clr,
  output logic [3:0]  row_o,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [31:0] digits
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_DB_PRESS, S_PRESSED, S_DB_REL} state_t;
  typedef enum logic [1:0] {C_NONE, C_SINGLE, C_MULTI} cls_t;

  logic [3:0]       r_col_s1, r_col_s2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row;
  logic [11:0]      r_samp;
  logic             r_frame_vld;
  cls_t             r_cls;
  logic [3:0]       r_code;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cand;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic [31:0]      r_digits;

  logic             w_tc;
  logic [15:0]      w_frame;
  logic [4:0]       w_nset;
  logic [3:0]       w_idx;
  cls_t             w_cls;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_cand_nxt;
  logic             w_accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= col_i;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_tc = (r_div == DIV_LAST);
  // Row 3 is classified straight from the synchronizer so the frame result lands on its terminal edge.
  assign w_frame = {~r_col_s2, r_samp};

  always_comb begin
    w_nset = '0;
    w_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_frame[i]) begin
        w_nset = w_nset + 5'd1;
        w_idx  = 4'(i);
      end
    end
    w_cls = C_MULTI;
    if (w_nset == 5'd0)      w_cls = C_NONE;
    else if (w_nset == 5'd1) w_cls = C_SINGLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div       <= '0;
      r_row       <= '0;
      r_samp      <= '0;
      r_frame_vld <= 1'b0;
      r_cls       <= C_NONE;
      r_code      <= '0;
    end else begin
      r_frame_vld <= 1'b0;
      if (w_tc) begin
        r_div <= '0;
        r_row <= r_row + 2'd1;
        case (r_row)
          2'd0: r_samp[3:0]  <= ~r_col_s2;
          2'd1: r_samp[7:4]  <= ~r_col_s2;
          2'd2: r_samp[11:8] <= ~r_col_s2;
          default: begin
            r_frame_vld <= 1'b1;
            r_cls       <= w_cls;
            r_code      <= w_idx;
          end
        endcase
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cand      <= w_cand_nxt;
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= r_cand;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    if (r_frame_vld) begin
      case (r_state)
        S_IDLE: begin
          if (r_cls == C_SINGLE) begin
            w_cand_nxt  = r_code;
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = S_DB_PRESS;
          end
        end
        S_DB_PRESS: begin
          if (r_cls == C_SINGLE && r_code == r_cand) begin
            if (r_cnt == CNT_LAST) begin
              w_state_nxt = S_PRESSED;
              w_cnt_nxt   = '0;
              w_accept    = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        S_PRESSED: begin
          if (r_cls == C_NONE) begin
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = S_DB_REL;
          end
        end
        S_DB_REL: begin
          if (r_cls == C_NONE) begin
            if (r_cnt == CNT_LAST) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end else begin
            w_state_nxt = S_PRESSED;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Clear takes priority over a same-cycle key entry.
  always_ff @(posedge clk) begin
    if (!reset)           r_digits <= '0;
    else if (clr)         r_digits <= '0;
    else if (r_key_valid) r_digits <= {r_digits[27:0], r_key_code};
  end

  always_comb begin
    row_o     = ~(4'b0001 << r_row);
    key_code  = r_key_code;
    key_valid = r_key_valid;
    key_down  = (r_state == S_PRESSED) || (r_state == S_DB_REL);
    digits    = r_digits;
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames).
module tb_keypad_scan_4x4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col_i;
  logic        clr;
  logic [3:0]  row_o;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [31:0] digits;
  logic [15:0] keys;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;
  int n_pulses = 0;
  int pulse_cyc = 0;
  int p_mark;
  int t0;
  logic [3:0] rows_exp [4];

  keypad_scan_4x4 #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .reset(reset), .col_i(col_i), .clr(clr), .row_o(row_o),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .digits(digits)
  );

  initial forever #5 clk = ~clk;

  // Keypad: a held key pulls its column low while its row is driven low.
  always_comb begin
    col_i = 4'hF;
    for (int k = 0; k < 16; k++)
      if (keys[k] && !row_o[k/4]) col_i[k%4] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (key_valid === 1'b1) begin
      n_pulses  <= n_pulses + 1;
      pulse_cyc <= cyc;
    end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_release(input int k);
    keys = '0;
    keys[k] = 1'b1;
    ticks(64);
    keys = '0;
    ticks(64);
  endtask

  initial begin
    rows_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset = 1'b0;
    clr   = 1'b0;
    keys  = '0;
    ticks(3);
    reset = 1'b1;

    // 1. reset state and row scan
    check("rst_row_o", row_o, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_down", key_down, 1'b0);
    check("rst_digits", digits, 32'h0);
    for (int k = 0; k < 32; k++) begin
      check("scan_row_o", row_o, rows_exp[(k/4)%4]);
      ticks(1);
    end

    // 2. clean press of key 6, then release
    p_mark = n_pulses;
    keys = '0; keys[6] = 1'b1;
    t0 = cyc;
    ticks(80);
    check("press6_pulses", n_pulses - p_mark, 1);
    check("press6_latency", pulse_cyc - t0, 49);
    check("press6_code", key_code, 4'h6);
    check("press6_down", key_down, 1'b1);
    check("press6_digits", digits, 32'h00000006);
    keys = '0;
    ticks(48);
    check("rel6_down_held", key_down, 1'b1);
    ticks(1);
    check("rel6_down_fall", key_down, 1'b0);
    ticks(15);
    check("rel6_no_extra", n_pulses - p_mark, 1);

    // 3. bounce on key F, then steady press
    p_mark = n_pulses;
    keys = '0; keys[15] = 1'b1;
    ticks(16);
    keys = '0;
    ticks(16);
    check("bounce_no_pulse", n_pulses - p_mark, 0);
    keys[15] = 1'b1;
    t0 = cyc;
    ticks(64);
    check("keyF_pulses", n_pulses - p_mark, 1);
    check("keyF_latency", pulse_cyc - t0, 49);
    check("keyF_code", key_code, 4'hF);
    keys = '0;
    ticks(64);
    check("keyF_released", key_down, 1'b0);

    // 4. two keys (ghosting) and release glitch on key 5
    p_mark = n_pulses;
    keys = '0; keys[3] = 1'b1; keys[9] = 1'b1;
    ticks(64);
    check("multi_no_pulse", n_pulses - p_mark, 0);
    check("multi_no_down", key_down, 1'b0);
    keys = '0;
    ticks(16);
    keys[5] = 1'b1;
    t0 = cyc;
    ticks(64);
    check("key5_pulses", n_pulses - p_mark, 1);
    check("key5_latency", pulse_cyc - t0, 49);
    check("key5_code", key_code, 4'h5);
    keys = '0;
    ticks(16);
    keys[5] = 1'b1;
    ticks(32);
    check("glitch_down_held", key_down, 1'b1);
    check("glitch_no_repeat", n_pulses - p_mark, 1);
    keys = '0;
    ticks(64);
    check("key5_released", key_down, 1'b0);
    check("digits_6F5", digits, 32'h000006F5);

    // 5. wrap the digit register, then clear on the key A pulse
    p_mark = n_pulses;
    for (int k = 1; k <= 9; k++) press_release(k);
    check("wrap_pulses", n_pulses - p_mark, 9);
    check("wrap_code", key_code, 4'h9);
    check("wrap_digits", digits, 32'h23456789);
    keys = '0; keys[10] = 1'b1;
    ticks(48);
    check("keyA_before", key_valid, 1'b0);
    ticks(1);
    check("keyA_valid", key_valid, 1'b1);
    check("keyA_code", key_code, 4'hA);
    clr = 1'b1;
    ticks(1);
    clr = 1'b0;
    check("clr_digits", digits, 32'h0);
    check("clr_code_kept", key_code, 4'hA);
    check("keyA_one_cycle", key_valid, 1'b0);
    ticks(14);
    keys = '0;
    ticks(64);

    // 6. reset during DB_PRESS and during PRESSED
    p_mark = n_pulses;
    keys = '0; keys[1] = 1'b1;
    ticks(40);
    reset = 1'b0;
    keys = '0;
    ticks(2);
    reset = 1'b1;
    check("rst1_valid", key_valid, 1'b0);
    check("rst1_down", key_down, 1'b0);
    check("rst1_row_o", row_o, 4'b1110);
    check("rst1_code", key_code, 4'h0);
    check("rst1_digits", digits, 32'h0);
    keys[1] = 1'b1;
    t0 = cyc;
    ticks(64);
    check("key1_pulses", n_pulses - p_mark, 1);
    check("key1_latency", pulse_cyc - t0, 49);
    check("key1_code", key_code, 4'h1);
    check("key1_down", key_down, 1'b1);
    check("key1_digits", digits, 32'h00000001);
    reset = 1'b0;
    keys = '0;
    ticks(1);
    check("rst2_down", key_down, 1'b0);
    check("rst2_digits", digits, 32'h0);
    ticks(1);
    reset = 1'b1;
    p_mark = n_pulses;
    keys[2] = 1'b1;
    t0 = cyc;
    ticks(64);
    check("key2_pulses", n_pulses - p_mark, 1);
    check("key2_latency", pulse_cyc - t0, 49);
    check("key2_code", key_code, 4'h2);
    check("key2_digits", digits, 32'h00000002);
    keys = '0;
    ticks(64);
    check("final_down", key_down, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
